// File: rtl/pipeline_mem_if.sv
// Data-memory port of the memory-access stage: request/acknowledge bus grouped
// so the stage (master) and the memory model (slave) share one definition.

`ifndef MEM_OPCODE_WIDTH
`define MEM_OPCODE_WIDTH 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

interface pipeline_mem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/pipeline_mem.sv
// Memory-access pipeline stage: one-entry buffer, single-outstanding data-memory
// transaction, registered write-back bus. Optional misalignment trap: MEM_ALIGN_CHECK_EN.

`ifndef MEM_OPCODE_WIDTH
`define MEM_OPCODE_WIDTH 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module pipeline_mem (
    input  logic                         CLK,
    input  logic                         RST_N,
    output logic                         prev_busy,
    input  logic [31:0]                  prev_insnPC,
    input  logic [2:0]                   prev_insn_id,
    input  logic [`MEM_OPCODE_WIDTH-1:0] mem_opcode,
    input  logic [31:0]                  mem_src1,
    input  logic [31:0]                  mem_src2,
    input  logic                         mem_src2_forward,
    input  logic [2:0]                   mem_src2_forward_from,
    pipeline_mem_if.master               dmem,
    output logic [2:0]                   write_back_insn_id,
    output logic [31:0]                  write_back_data,
    output logic [31:0]                  write_back_insnPC,
    output logic                         write_back_en,
    output logic                         mem_exc
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    localparam int OPW = `MEM_OPCODE_WIDTH;
    localparam logic [2:0] NO_ID = 3'b111;

    function automatic logic is_load(input logic [OPW-1:0] op);
        case (op)
            `MEM_LB, `MEM_LBU, `MEM_LH, `MEM_LHU, `MEM_LW: is_load = 1'b1;
            default:                                      is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [OPW-1:0] op);
        case (op)
            `MEM_SB, `MEM_SH, `MEM_SW: is_store = 1'b1;
            default:                   is_store = 1'b0;
        endcase
    endfunction

    // Byte enables follow the access size for both loads and stores.
    function automatic logic [3:0] access_be(input logic [OPW-1:0] op, input logic [1:0] lane);
        case (op)
            `MEM_LB, `MEM_LBU, `MEM_SB: access_be = 4'b0001 << lane;
            `MEM_LH, `MEM_LHU, `MEM_SH: access_be = lane[1] ? 4'b1100 : 4'b0011;
            default:                    access_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [OPW-1:0] op, input logic [31:0] data);
        case (op)
            `MEM_SB: store_wdata = {4{data[7:0]}};
            `MEM_SH: store_wdata = {2{data[15:0]}};
            `MEM_SW: store_wdata = data;
            default: store_wdata = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [OPW-1:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (op)
            `MEM_LB:  load_format = {{24{byte_v[7]}}, byte_v};
            `MEM_LBU: load_format = {24'd0, byte_v};
            `MEM_LH:  load_format = {{16{half_v[15]}}, half_v};
            `MEM_LHU: load_format = {16'd0, half_v};
            `MEM_LW:  load_format = word;
            default:  load_format = 32'd0;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [2:0]       buf_id_r, buf_id_s;
    logic [31:0]      buf_pc_r, buf_pc_s;
    logic [OPW-1:0]   buf_op_r, buf_op_s;
    logic [31:0]      buf_addr_r, buf_addr_s;
    logic [31:0]      buf_data_r, buf_data_s;
    logic             buf_wb_en_r, buf_wb_en_s;
    logic             buf_exc_r, buf_exc_s;
    logic             pend_r, pend_s;
    logic [2:0]       pend_from_r, pend_from_s;
    logic             misalign_s;

    logic             busy_r, busy_s;
    logic             req_r, req_s;
    logic             we_r, we_s;
    logic [31:0]      addr_r, addr_s;
    logic [3:0]       be_r, be_s;
    logic [31:0]      wdata_r, wdata_s;
    logic [2:0]       wb_id_r, wb_id_s;
    logic [31:0]      wb_data_r, wb_data_s;
    logic [31:0]      wb_pc_r, wb_pc_s;
    logic             wb_en_r, wb_en_s;
    logic             exc_r, exc_s;

    // Next buffer/state and next registered outputs.
    always_comb begin
        state_s     = state_r;
        buf_id_s    = buf_id_r;
        buf_pc_s    = buf_pc_r;
        buf_op_s    = buf_op_r;
        buf_addr_s  = buf_addr_r;
        buf_data_s  = buf_data_r;
        buf_wb_en_s = buf_wb_en_r;
        buf_exc_s   = buf_exc_r;
        pend_s      = pend_r;
        pend_from_s = pend_from_r;
`ifdef MEM_ALIGN_CHECK_EN
        case (mem_opcode)
            `MEM_LH, `MEM_LHU, `MEM_SH: misalign_s = mem_src1[0];
            `MEM_LW, `MEM_SW:           misalign_s = (mem_src1[1:0] != 2'b00);
            default:                    misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif

        if (state_r != ST_ACCESS) begin
            if (prev_insn_id == NO_ID) begin
                state_s  = ST_EMPTY;
                buf_id_s = NO_ID;
            end else begin
                buf_id_s    = prev_insn_id;
                buf_pc_s    = prev_insnPC;
                buf_op_s    = mem_opcode;
                buf_addr_s  = mem_src1;
                buf_exc_s   = 1'b0;
                pend_s      = 1'b0;
                pend_from_s = mem_src2_forward_from;
                if (mem_opcode == `MEM_NOP) begin
                    state_s     = ST_COMPLETE;
                    buf_data_s  = mem_src1;
                    buf_wb_en_s = 1'b1;
                end else if (is_load(mem_opcode) || is_store(mem_opcode)) begin
                    buf_wb_en_s = is_load(mem_opcode);
                    if (misalign_s) begin
                        state_s     = ST_COMPLETE;
                        buf_exc_s   = 1'b1;
                        buf_wb_en_s = 1'b0;
                        buf_data_s  = 32'd0;
                    end else begin
                        state_s = ST_ACCESS;
                        // Store data may be the value retiring on our own write-back bus right now.
                        if (mem_src2_forward && (mem_src2_forward_from == wb_id_r)) begin
                            buf_data_s = wb_data_r;
                        end else begin
                            buf_data_s = mem_src2;
                            pend_s     = mem_src2_forward;
                        end
                    end
                end else begin
                    state_s     = ST_COMPLETE;
                    buf_data_s  = 32'd0;
                    buf_wb_en_s = 1'b0;
                end
            end
        end else begin
            if (pend_r && (pend_from_r == wb_id_r)) begin
                buf_data_s = wb_data_r;
                pend_s     = 1'b0;
            end else begin
                pend_s = pend_r;
            end
            // An ack only counts while a request is actually on the bus.
            if (req_r && dmem.dmem_ack) begin
                state_s = ST_COMPLETE;
                if (is_load(buf_op_r)) begin
                    buf_data_s = load_format(buf_op_r, buf_addr_r[1:0], dmem.dmem_rdata);
                end else begin
                    buf_data_s = buf_data_r;
                end
            end else begin
                state_s = ST_ACCESS;
            end
        end

        busy_s = (state_s == ST_ACCESS);
        req_s  = (state_s == ST_ACCESS) && !pend_s;
        if (state_s == ST_ACCESS) begin
            we_s    = is_store(buf_op_s);
            addr_s  = {buf_addr_s[31:2], 2'b00};
            be_s    = access_be(buf_op_s, buf_addr_s[1:0]);
            wdata_s = store_wdata(buf_op_s, buf_data_s);
        end else begin
            we_s    = 1'b0;
            addr_s  = 32'd0;
            be_s    = 4'd0;
            wdata_s = 32'd0;
        end

        if (state_s == ST_COMPLETE) begin
            wb_id_s   = buf_id_s;
            wb_data_s = buf_data_s;
            wb_pc_s   = buf_pc_s;
            wb_en_s   = buf_wb_en_s;
            exc_s     = buf_exc_s;
        end else begin
            wb_id_s   = NO_ID;
            wb_data_s = 32'd0;
            wb_pc_s   = 32'd0;
            wb_en_s   = 1'b0;
            exc_s     = 1'b0;
        end
    end

    // State, buffer and output registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_EMPTY;
            buf_id_r    <= NO_ID;
            buf_pc_r    <= 32'd0;
            buf_op_r    <= `MEM_NOP;
            buf_addr_r  <= 32'd0;
            buf_data_r  <= 32'd0;
            buf_wb_en_r <= 1'b0;
            buf_exc_r   <= 1'b0;
            pend_r      <= 1'b0;
            pend_from_r <= NO_ID;
            busy_r      <= 1'b0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            be_r        <= 4'd0;
            wdata_r     <= 32'd0;
            wb_id_r     <= NO_ID;
            wb_data_r   <= 32'd0;
            wb_pc_r     <= 32'd0;
            wb_en_r     <= 1'b0;
            exc_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            buf_id_r    <= buf_id_s;
            buf_pc_r    <= buf_pc_s;
            buf_op_r    <= buf_op_s;
            buf_addr_r  <= buf_addr_s;
            buf_data_r  <= buf_data_s;
            buf_wb_en_r <= buf_wb_en_s;
            buf_exc_r   <= buf_exc_s;
            pend_r      <= pend_s;
            pend_from_r <= pend_from_s;
            busy_r      <= busy_s;
            req_r       <= req_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            be_r        <= be_s;
            wdata_r     <= wdata_s;
            wb_id_r     <= wb_id_s;
            wb_data_r   <= wb_data_s;
            wb_pc_r     <= wb_pc_s;
            wb_en_r     <= wb_en_s;
            exc_r       <= exc_s;
        end
    end

    assign prev_busy          = busy_r;
    assign dmem.dmem_req      = req_r;
    assign dmem.dmem_we       = we_r;
    assign dmem.dmem_addr     = addr_r;
    assign dmem.dmem_be       = be_r;
    assign dmem.dmem_wdata    = wdata_r;
    assign write_back_insn_id = wb_id_r;
    assign write_back_data    = wb_data_r;
    assign write_back_insnPC  = wb_pc_r;
    assign write_back_en      = wb_en_r;
    assign mem_exc            = exc_r;

endmodule

// File: tb/tb_pipeline_mem.sv
// Randomized bench for pipeline_mem against a transaction-level model of the
// memory stage; directed cases cover forwarding, reset mid-access and alignment.

`ifndef MEM_OPCODE_WIDTH
`define MEM_OPCODE_WIDTH 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

`timescale 1ns/1ps

module tb_pipeline_mem;
    localparam int OPW = `MEM_OPCODE_WIDTH;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           prev_busy;
    logic [31:0]    prev_insnPC;
    logic [2:0]     prev_insn_id;
    logic [OPW-1:0] mem_opcode;
    logic [31:0]    mem_src1, mem_src2;
    logic           mem_src2_forward;
    logic [2:0]     mem_src2_forward_from;
    logic [2:0]     write_back_insn_id;
    logic [31:0]    write_back_data, write_back_insnPC;
    logic           write_back_en, mem_exc;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_mem_if dmem ();

    pipeline_mem dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .prev_busy             (prev_busy),
        .prev_insnPC           (prev_insnPC),
        .prev_insn_id          (prev_insn_id),
        .mem_opcode            (mem_opcode),
        .mem_src1              (mem_src1),
        .mem_src2              (mem_src2),
        .mem_src2_forward      (mem_src2_forward),
        .mem_src2_forward_from (mem_src2_forward_from),
        .dmem                  (dmem),
        .write_back_insn_id    (write_back_insn_id),
        .write_back_data       (write_back_data),
        .write_back_insnPC     (write_back_insnPC),
        .write_back_en         (write_back_en),
        .mem_exc               (mem_exc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input logic [OPW-1:0] op);
        return (op == `MEM_LB) || (op == `MEM_LBU) || (op == `MEM_LH) ||
               (op == `MEM_LHU) || (op == `MEM_LW);
    endfunction

    function automatic bit m_is_store(input logic [OPW-1:0] op);
        return (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
    endfunction

    function automatic int m_size(input logic [OPW-1:0] op);
        if (op == `MEM_LB || op == `MEM_LBU || op == `MEM_SB) return 1;
        if (op == `MEM_LH || op == `MEM_LHU || op == `MEM_SH) return 2;
        return 4;
    endfunction

    function automatic bit m_misaligned(input logic [OPW-1:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        return (addr % m_size(op)) != 0;
`else
        return (op == 4'd15) && (addr == 32'd1);
`endif
    endfunction

    function automatic logic [3:0] m_be(input logic [OPW-1:0] op, input logic [31:0] addr);
        int sz;
        int first;
        sz = m_size(op);
        first = (sz == 1) ? addr % 4 : ((sz == 2) ? (addr % 4) / 2 * 2 : 0);
        return 4'(((1 << sz) - 1) << first);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [OPW-1:0] op, input logic [31:0] d);
        if (m_size(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (m_size(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [OPW-1:0] op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
        logic [31:0] shifted;
        byte         sb;
        shortint     sh;
        logic [31:0] r;
        if (m_size(op) == 1) shifted = rdata >> (8 * (addr % 4));
        else                 shifted = rdata >> (16 * ((addr % 4) / 2));
        sb = byte'(shifted & 32'hFF);
        sh = shortint'(shifted & 32'hFFFF);
        case (op)
            `MEM_LB:  r = sb;
            `MEM_LBU: r = shifted & 32'hFF;
            `MEM_LH:  r = sh;
            `MEM_LHU: r = shifted & 32'hFFFF;
            default:  r = rdata;
        endcase
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic present(input logic [2:0] id, input logic [31:0] pc, input logic [OPW-1:0] op,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic fwd, input logic [2:0] from);
        prev_insn_id          = id;
        prev_insnPC           = pc;
        mem_opcode            = op;
        mem_src1              = s1;
        mem_src2              = s2;
        mem_src2_forward      = fwd;
        mem_src2_forward_from = from;
        step();
        prev_insn_id     = 3'b111;
        mem_src2_forward = 1'b0;
        mem_opcode       = `MEM_NOP;
    endtask

    task automatic do_nop(input logic [2:0] id, input logic [31:0] pc, input logic [31:0] s1);
        check("nop_busy_at_accept", prev_busy, 0);
        present(id, pc, `MEM_NOP, s1, 32'd0, 1'b0, 3'd0);
        check("nop_id", write_back_insn_id, id);
        check("nop_data", write_back_data, s1);
        check("nop_en", write_back_en, 1);
        check("nop_pc", write_back_insnPC, pc);
        check("nop_busy", prev_busy, 0);
        check("nop_req", dmem.dmem_req, 0);
    endtask

    // Runs one load/store from accept to its retire cycle (left visible).
    task automatic do_mem(input logic [2:0] id, input logic [OPW-1:0] op, input logic [31:0] addr,
                          input logic [31:0] s2, input logic [31:0] rdata, input int nwait);
        logic [31:0] pc;
        pc = 32'h1000 + 32'(id) * 4;
        present(id, pc, op, addr, s2, 1'b0, 3'd0);
        if (m_misaligned(op, addr)) begin
            check("mis_req", dmem.dmem_req, 0);
            check("mis_busy", prev_busy, 0);
            check("mis_exc", mem_exc, 1);
            check("mis_en", write_back_en, 0);
            check("mis_id", write_back_insn_id, id);
        end else begin
            for (int i = 0; i < nwait; i++) begin
                check("acc_busy", prev_busy, 1);
                check("acc_req", dmem.dmem_req, 1);
                check("acc_we", dmem.dmem_we, m_is_store(op));
                check("acc_addr", dmem.dmem_addr, addr & ~32'h3);
                check("acc_be", dmem.dmem_be, m_be(op, addr));
                if (m_is_store(op)) check("acc_wdata", dmem.dmem_wdata, m_wdata(op, s2));
                check("acc_wb_id", write_back_insn_id, 3'b111);
                if (i == nwait - 1) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = rdata;
                end
                step();
            end
            dmem.dmem_ack   = 1'b0;
            dmem.dmem_rdata = $urandom;
            check("ret_id", write_back_insn_id, id);
            check("ret_pc", write_back_insnPC, pc);
            check("ret_en", write_back_en, m_is_load(op));
            if (m_is_load(op)) check("ret_data", write_back_data, m_load(op, addr, rdata));
            check("ret_exc", mem_exc, 0);
            check("ret_busy", prev_busy, 0);
            check("ret_req", dmem.dmem_req, 0);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        prev_insn_id = 3'b111; prev_insnPC = 32'd0; mem_opcode = `MEM_NOP;
        mem_src1 = 32'd0; mem_src2 = 32'd0; mem_src2_forward = 1'b0; mem_src2_forward_from = 3'd0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;
        step(); step();
        check("rst_wb_id", write_back_insn_id, 3'b111);
        check("rst_busy", prev_busy, 0);
        check("rst_req", dmem.dmem_req, 0);
        check("rst_en", write_back_en, 0);
        check("rst_data", write_back_data, 0);
        check("rst_exc", mem_exc, 0);
        RST_N = 1'b1;
        step();

        do_nop(3'd2, 32'h0000_0040, 32'h1234_5678);
        step();
        check("empty_id", write_back_insn_id, 3'b111);
        check("empty_en", write_back_en, 0);

        do_mem(3'd1, `MEM_LB, 32'h102, 32'd0, 32'h0080_0000, 3);
        check("lb_value", write_back_data, 32'hFFFF_FF80);
        do_mem(3'd1, `MEM_LBU, 32'h102, 32'd0, 32'h0080_0000, 2);
        check("lbu_value", write_back_data, 32'h0000_0080);
        do_mem(3'd4, `MEM_SH, 32'h206, 32'h0000_ABCD, 32'd0, 1);

        // Store data forwarded from the load retiring on the accept edge.
        do_mem(3'd3, `MEM_LW, 32'h80, 32'd0, 32'hDEAD_BEEF, 1);
        present(3'd4, 32'h2000, `MEM_SW, 32'h90, 32'h1111_1111, 1'b1, 3'd3);
        check("fwd_req", dmem.dmem_req, 1);
        check("fwd_wdata", dmem.dmem_wdata, 32'hDEAD_BEEF);
        check("fwd_be", dmem.dmem_be, 4'hF);
        dmem.dmem_ack = 1'b1;
        step();
        dmem.dmem_ack = 1'b0;
        check("fwd_ret_id", write_back_insn_id, 3'd4);
        check("fwd_ret_en", write_back_en, 0);

        // Pending store: tag 3'b111 matches only once our own bus idles (value 0).
        do_nop(3'd2, 32'h44, 32'h7777_0000);
        present(3'd5, 32'h2004, `MEM_SW, 32'h40, 32'h5555_5555, 1'b1, 3'b111);
        check("pend_req_low", dmem.dmem_req, 0);
        check("pend_busy", prev_busy, 1);
        dmem.dmem_ack = 1'b1;
        step();
        check("pend_req_high", dmem.dmem_req, 1);
        check("pend_wdata", dmem.dmem_wdata, 32'd0);
        step();
        dmem.dmem_ack = 1'b0;
        check("pend_ret_id", write_back_insn_id, 3'd5);

        // Source never retires: request must stay low.
        step();
        present(3'd6, 32'h2008, `MEM_SW, 32'h50, 32'h0, 1'b1, 3'd5);
        for (int i = 0; i < 3; i++) begin
            check("stuck_req", dmem.dmem_req, 0);
            check("stuck_busy", prev_busy, 1);
            step();
        end
        RST_N = 1'b0;
        #2 RST_N = 1'b1;
        step();

        // Asynchronous reset while a request is outstanding.
        present(3'd1, 32'h3000, `MEM_LW, 32'h10, 32'd0, 1'b0, 3'd0);
        check("mid_req_before", dmem.dmem_req, 1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_req_drop", dmem.dmem_req, 0);
        check("mid_wb_id", write_back_insn_id, 3'b111);
        check("mid_busy", prev_busy, 0);
        #2 RST_N = 1'b1;
        dmem.dmem_ack = 1'b1;
        dmem.dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem.dmem_ack = 1'b0;
        check("late_ack_id", write_back_insn_id, 3'b111);
        check("late_ack_req", dmem.dmem_req, 0);
        check("late_ack_en", write_back_en, 0);

        do_mem(3'd2, `MEM_LW, 32'h301, 32'd0, 32'h0102_0304, 1);
        step();
        check("after_align_exc", mem_exc, 0);

        for (int t = 0; t < 40; t++) begin
            logic [OPW-1:0] op;
            logic [2:0]     id;
            op = OPW'($urandom_range(0, 8));
            id = 3'($urandom_range(0, 6));
            if (op == `MEM_NOP) do_nop(id, $urandom, $urandom);
            else do_mem(id, op, $urandom, $urandom, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("rand_idle_id", write_back_insn_id, 3'b111);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
